stream_buffer: RTL
==================

// Module: stream_buffer
// PURPOSE
//  Parametrised store-then-stream staging buffer feeding systolic-array operand lanes.
//  STORE mode accepts IN_W-bit words over a valid/ready handshake into a DEPTH-entry circular store.
//  STREAM mode emits PACK words per beat as one OUT_W-bit word, with a zero-padded tail beat.
//  Adds full/empty/count/overflow status and a CLEAR mode.
// PARAMETERS
//  IN_W   32    input word width (bits)
//  PACK   2     input words packed per output beat; OUT_W = IN_W*PACK
//  DEPTH  1024  storage depth in IN_W words; power of two, >= 2*PACK
//  ADDR_W $clog2(DEPTH)  pointer width (derived, do not override)
// PORTS
//  clk        in   1          clock; all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  mode       in   2          buf_mode_e: 00 IDLE, 01 STORE, 10 STREAM, 11 CLEAR
//  in_valid   in   1          data_in valid
//  in_ready   out  1          buffer accepts data_in this cycle
//  data_in    in   IN_W       word to store
//  out_valid  out  1          data_out holds a beat
//  out_ready  in   1          consumer accepts the beat
//  data_out   out  PACK*IN_W  packed beat; oldest word in bits [IN_W-1:0]
//  out_last   out  1          beat is the last one; words still stored == 0 after it
//  count      out  ADDR_W+1   words currently stored
//  full       out  1          count == DEPTH
//  empty      out  1          count == 0
//  ovf        out  1          sticky: in_valid seen in STORE while full
// BEHAVIOUR
//  Reset: in_ready=0, out_valid=0, data_out=0, out_last=0, count=0, empty=1, full=0, ovf=0.
//  Reset: wr_ptr=rd_ptr=0. Reset mid-operation discards all contents and any held beat.
//  in_ready = (mode==STORE) && !full, combinational. Write on in_valid && in_ready.
//  Write goes to mem[wr_ptr]; wr_ptr wraps DEPTH-1 -> 0; count +1.
//  STORE while full: word dropped, ovf set; ovf clears only on rst or CLEAR.
//  STREAM beat load: registered, 1-cycle latency.
//  Load when mode==STREAM && count>0 && (!out_valid || out_ready).
//  Load packs min(count,PACK) words from rd_ptr upward, wrapping; missing lanes are 0.
//  Load advances rd_ptr, decreases count by the words taken, sets out_valid; out_last=(count after load == 0).
//  Back-to-back beats: with out_ready held high, one beat per cycle.
//  No load while count==0: out_valid falls after acceptance. Empty stream is not an error.
//  Held beat: data_out/out_valid/out_last stay stable until out_ready, in every mode except CLEAR.
//  Leaving STREAM does not drop a held beat. data_out holds its last value when out_valid=0.
//  CLEAR (one cycle): pointers, count, ovf and out_valid/out_last to 0; data_out to 0.
//  IDLE: no writes, no loads; held beat persists.
//  Reads and writes never occur in the same cycle; mode selects exactly one.
// CONFIGURATION
//  BUF_REPLAY_EN defined: a load does not decrement count; it advances a separate remaining counter.
//   out_last = remaining reaches 0. After the last beat is accepted, rd_ptr rewinds to base (oldest word).
//   Remaining reloads to count, so the next STREAM episode replays identical data (weight reuse).
//   STORE appends after the replay window. CLEAR empties it.
//  BUF_REPLAY_EN undefined: streamed words are freed (count decrements). No base/remaining logic.
// STRUCTURE
//  Package systolic_pkg (shared): buf_mode_e enum (IDLE/STORE/STREAM/CLEAR); BUF_MODE_W=2 constant.
//  Sub-module stream_buffer_mem (natural split): DEPTH x IN_W register array.
//   One write port and a combinational PACK-word wrapping read port at rd_ptr.
//  Top: pointers, count, handshake and the output register.
// TESTING  (IN_W=32, PACK=2, DEPTH=8 unless noted)
//  Reset: rst=1 for 2 cycles -> all outputs at reset values, empty=1, count=0.
//  STORE 8 words 0x11..0x88 -> full=1, in_ready=0, count=8.
//   A 9th in_valid -> ovf=1, count stays 8.
//  STREAM, out_ready=1 after storing 0xDEADBEEF,0xCAFEBABE -> 1 cycle later:
//   data_out=0xCAFEBABE_DEADBEEF, out_valid=1, out_last=1, then empty=1.
//  Odd tail: store 3 words A,B,C then STREAM -> beats {B,A}, then {0,C} with out_last=1.
//  Backpressure: out_ready=0 for 4 cycles, mode switched to IDLE -> beat held stable.
//   After out_ready=1, beat accepted once, no duplication.
//  Wrap: store 6, stream 6, store 6 -> wr_ptr wraps to 4, stream returns words in order.
//  CLEAR while out_valid=1 and ovf=1 -> next cycle count=0, empty=1, out_valid=0, ovf=0.
//  With BUF_REPLAY_EN: store 4 words, stream twice -> identical 2-beat sequences, count stays 4.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared buffer mode encoding for the systolic operand staging path
package systolic_pkg;

    localparam int BUF_MODE_W = 2;

    typedef enum logic [BUF_MODE_W-1:0] {
        BUF_IDLE   = 2'b00,
        BUF_STORE  = 2'b01,
        BUF_STREAM = 2'b10,
        BUF_CLEAR  = 2'b11
    } buf_mode_e;

    // Number of words a beat can take when avail words remain.
    function automatic int unsigned beat_words(input int unsigned avail, input int unsigned pack);
        return (avail >= pack) ? pack : avail;
    endfunction

endpackage

// File: rtl/stream_buffer_if.sv
// rtl/stream_buffer_if.sv - input word handshake and packed output beat handshake
interface stream_buffer_if #(
    parameter int IN_W = 32,
    parameter int PACK = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      data_in;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [IN_W*PACK-1:0] data_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, out_last, data_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, out_last, data_out
    );
endinterface

// File: rtl/stream_buffer_mem.sv
// rtl/stream_buffer_mem.sv - DEPTH x IN_W word store, one write port, PACK-word wrapping read window
module stream_buffer_mem #(
    parameter int IN_W   = 32,
    parameter int PACK   = 2,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [IN_W-1:0]      wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [IN_W*PACK-1:0] rd_words
);

    logic [IN_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Lane i reads rd_addr+i; the pointer width makes the wrap free.
    always_comb begin
        rd_words = '0;
        for (int i = 0; i < PACK; i++) begin
            rd_words[i*IN_W +: IN_W] = mem[rd_addr + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/stream_buffer.sv
// rtl/stream_buffer.sv - store-then-stream staging buffer; BUF_REPLAY_EN keeps streamed words for replay
module stream_buffer
    import systolic_pkg::*;
#(
    parameter  int IN_W   = 32,
    parameter  int PACK   = 2,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  buf_mode_e         mode,
    stream_buffer_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ovf
);

    localparam int               OUT_W  = IN_W * PACK;
    localparam logic [ADDR_W:0]  CAP    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  PACK_C = (ADDR_W+1)'(PACK);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   avail;
    logic [ADDR_W:0]   take;
    logic [ADDR_W:0]   avail_after;
    logic [OUT_W-1:0]  rd_words;
    logic [OUT_W-1:0]  beat;
    logic              wr_en;
    logic              load;
    logic              accept;

`ifdef BUF_REPLAY_EN
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   remaining;
    assign avail = remaining;
`else
    assign avail = count;
`endif

    assign full         = (count == CAP);
    assign empty        = (count == '0);
    assign bus.in_ready = (mode == BUF_STORE) && !full;
    assign wr_en        = bus.in_ready && bus.in_valid;
    assign accept       = bus.out_valid && bus.out_ready;
    assign load         = (mode == BUF_STREAM) && (avail != '0) && (!bus.out_valid || bus.out_ready);
    assign take         = (avail >= PACK_C) ? PACK_C : avail;
    assign avail_after  = avail - take;

    stream_buffer_mem #(
        .IN_W   (IN_W),
        .PACK   (PACK),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr),
        .wr_data  (bus.data_in),
        .rd_addr  (rd_ptr),
        .rd_words (rd_words)
    );

    // Lanes past the words still available are zero padded.
    always_comb begin
        beat = '0;
        for (int i = 0; i < PACK; i++) begin
            if ((ADDR_W+1)'(i) < take) begin
                beat[i*IN_W +: IN_W] = rd_words[i*IN_W +: IN_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || mode == BUF_CLEAR) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.data_out  <= '0;
`ifdef BUF_REPLAY_EN
            base          <= '0;
            remaining     <= '0;
`endif
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (mode == BUF_STORE && bus.in_valid && full) begin
                ovf <= 1'b1;
            end

            if (load) begin
                rd_ptr        <= rd_ptr + take[ADDR_W-1:0];
                bus.out_valid <= 1'b1;
                bus.data_out  <= beat;
                bus.out_last  <= (avail_after == '0);
`ifdef BUF_REPLAY_EN
                remaining     <= avail_after;
`else
                count         <= count - take;
`endif
            end else if (accept) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end

`ifdef BUF_REPLAY_EN
            // Accepting the final beat rewinds to the oldest word for the next episode.
            if (!load && accept && bus.out_last) begin
                rd_ptr    <= base;
                remaining <= count + {{ADDR_W{1'b0}}, wr_en};
            end else if (wr_en) begin
                remaining <= remaining + 1'b1;
            end
`endif
        end
    end

endmodule
